// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input and instruction-memory write port of the ARM instruction encoder/loader.
// The slave modport is the encoder's view; master is the boot/test driver and memory side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_class;
    logic [3:0]        in_cond;
    logic [3:0]        in_cmd;
    logic              in_I;
    logic              in_S;
    logic              in_U;
    logic              in_L;
    logic [3:0]        in_Rn;
    logic [3:0]        in_Rd;
    logic [3:0]        in_Rm;
    logic [23:0]       in_imm;
    logic              in_last;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] word_count;
    logic              done;
    logic              err_illegal;
    logic [31:0]       checksum;

    modport master (
        output in_valid, in_class, in_cond, in_cmd, in_I, in_S, in_U, in_L,
               in_Rn, in_Rd, in_Rm, in_imm, in_last, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data, word_count, done,
               err_illegal, checksum
    );

    modport slave (
        input  in_valid, in_class, in_cond, in_cmd, in_I, in_S, in_U, in_L,
               in_Rn, in_Rd, in_Rm, in_imm, in_last, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data, word_count, done,
               err_illegal, checksum
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// ARM field-to-word encoder feeding a small FIFO that streams words into instruction memory.
// Optional: define ENC_CHECKSUM_EN for a rotate-xor checksum over every written word.
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   CLK,
    input  logic                   Reset_n,
    instr_encoder_loader_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    function automatic logic [31:0] encode_fields(
        input logic [1:0]  cls,
        input logic [3:0]  cond,
        input logic [3:0]  cmd,
        input logic        i_bit,
        input logic        s_bit,
        input logic        u_bit,
        input logic        l_bit,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [3:0]  rm,
        input logic [23:0] imm
    );
        logic        test_op;
        logic [11:0] op2;
        logic [31:0] word;
        // TST/TEQ/CMP/CMN always set flags and have no destination
        test_op = (cmd[3:2] == 2'b10);
        op2     = i_bit ? {4'h0, imm[7:0]} : {8'h00, rm};
        word    = '0;
        case (cls)
            2'b00:   word = {cond, 2'b00, i_bit, cmd, s_bit | test_op, rn,
                             test_op ? 4'h0 : rd, op2};
            2'b01:   word = {cond, 2'b01, 1'b0, 1'b1, u_bit, 1'b0, 1'b0, l_bit,
                             rn, rd, imm[11:0]};
            2'b10:   word = {cond, 3'b101, 1'b0, imm};
            default: word = '0;
        endcase
        return word;
    endfunction

    logic [32:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              full, empty, accept, push, pop;
    logic [32:0]       push_entry;
    logic [32:0]       head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                    (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign accept = bus.in_valid && !full;
    // Illegal bundles complete the handshake but never occupy a slot
    assign push   = accept && (bus.in_class != 2'b11);
    assign pop    = !empty && bus.wr_ready;
    assign head   = fifo_q[rd_ptr_q[IDX_W-1:0]];

    assign push_entry = {bus.in_last,
                         encode_fields(bus.in_class, bus.in_cond, bus.in_cmd,
                                       bus.in_I, bus.in_S, bus.in_U, bus.in_L,
                                       bus.in_Rn, bus.in_Rd, bus.in_Rm, bus.in_imm)};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        count_d  = count_q;
        done_d   = done_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (accept) begin
            done_d = 1'b0;
            if (bus.in_class == 2'b11) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(4);
            count_d  = count_q + ADDR_W'(1);
            // A last-word write beats a coincident accept
            if (head[32]) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (pop) begin
            checksum_d = {checksum_q[30:0], checksum_q[31]} ^ head[31:0];
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = 32'h0;
`endif

    assign bus.in_ready    = !full;
    assign bus.wr_valid    = !empty;
    assign bus.wr_data     = head[31:0];
    assign bus.wr_addr     = addr_q;
    assign bus.word_count  = count_q;
    assign bus.done        = done_q;
    assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: a queue-based reference model is updated every
// cycle from the pins and compared against all outputs, plus directed encodings and corner cases.
module tb_instr_encoder_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    typedef struct {
        logic [31:0] word;
        logic        last;
    } ent_t;

    logic CLK;
    logic Reset_n;
    int   n_checks;
    int   n_pass;
    int   rdy_mode;
    int   n_sent;

    ent_t              model_q[$];
    ent_t              hd;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] exp_cnt;
    logic              exp_done;
    logic              exp_err;
    logic [31:0]       exp_csum;
    int                sz;
    logic              xfer;
    logic              acc;
    logic              nd;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Reference encoding built from bit positions of the ARM word format
    function automatic logic [31:0] ref_encode(
        input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
        input logic ib, input logic sb, input logic ub, input logic lb,
        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
        input logic [23:0] imm);
        logic [31:0] w;
        logic        is_cmp;
        w = 32'(cond) << 28;
        is_cmp = (cmd >= 4'd8) && (cmd <= 4'd11);
        case (cls)
            2'd0: begin
                w = w | (32'(ib) << 25) | (32'(cmd) << 21) | (32'(is_cmp | sb) << 20)
                      | (32'(rn) << 16);
                if (!is_cmp) w = w | (32'(rd) << 12);
                if (ib) w = w | (32'(imm) & 32'hFF);
                else    w = w | 32'(rm);
            end
            2'd1: w = w | (32'h1 << 26) | (32'h1 << 24) | (32'(ub) << 23) | (32'(lb) << 20)
                        | (32'(rn) << 16) | (32'(rd) << 12) | (32'(imm) & 32'hFFF);
            2'd2: w = w | (32'h5 << 25) | 32'(imm);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Cycle model: every negedge predicts outputs, then applies the coming edge's events
    always @(negedge CLK) begin
        if (!Reset_n) begin
            model_q.delete();
            exp_addr = '0;
            exp_cnt  = '0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_csum = 32'h0;
        end else begin
            sz = model_q.size();
            check("in_ready",    32'(bus.in_ready),    32'(sz < DEPTH));
            check("wr_valid",    32'(bus.wr_valid),    32'(sz > 0));
            check("wr_addr",     32'(bus.wr_addr),     32'(exp_addr));
            check("word_count",  32'(bus.word_count),  32'(exp_cnt));
            check("done",        32'(bus.done),        32'(exp_done));
            check("err_illegal", 32'(bus.err_illegal), 32'(exp_err));
            check("checksum",    bus.checksum,         exp_csum);
            if (sz > 0) check("wr_data", bus.wr_data, model_q[0].word);
            xfer = (sz > 0) && bus.wr_ready;
            acc  = bus.in_valid && (sz < DEPTH);
            nd   = exp_done;
            if (acc) nd = 1'b0;
            if (xfer) begin
                hd = model_q.pop_front();
                if (hd.last) nd = 1'b1;
`ifdef ENC_CHECKSUM_EN
                exp_csum = {exp_csum[30:0], exp_csum[31]} ^ hd.word;
`endif
                exp_addr = exp_addr + 10'd4;
                exp_cnt  = exp_cnt + 10'd1;
            end
            if (acc) begin
                if (bus.in_class == 2'd3) exp_err = 1'b1;
                else model_q.push_back('{ref_encode(bus.in_class, bus.in_cond, bus.in_cmd,
                                                    bus.in_I, bus.in_S, bus.in_U, bus.in_L,
                                                    bus.in_Rn, bus.in_Rd, bus.in_Rm,
                                                    bus.in_imm), bus.in_last});
            end
            exp_done = nd;
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: bus.wr_ready = 1'b1;
                1: bus.wr_ready = 1'b0;
                default: bus.wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic ib, input logic sb, input logic ub, input logic lb,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                        input logic [23:0] imm, input logic last);
        logic took;
        took = 1'b0;
        bus.in_class = cls; bus.in_cond = cond; bus.in_cmd = cmd;
        bus.in_I = ib; bus.in_S = sb; bus.in_U = ub; bus.in_L = lb;
        bus.in_Rn = rn; bus.in_Rd = rd; bus.in_Rm = rm;
        bus.in_imm = imm; bus.in_last = last;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge CLK);
            took = bus.in_ready;
            @(posedge CLK);
            #1;
            if (took) break;
        end
        bus.in_valid = 1'b0;
        check("send_accept", 32'(took), 32'h1);
    endtask

    task automatic send_expect(input string tag, input logic [1:0] cls, input logic [3:0] cond,
                               input logic [3:0] cmd, input logic ib, input logic sb,
                               input logic ub, input logic lb, input logic [3:0] rn,
                               input logic [3:0] rd, input logic [3:0] rm,
                               input logic [23:0] imm, input logic [31:0] exp_word);
        send(cls, cond, cmd, ib, sb, ub, lb, rn, rd, rm, imm, 1'b0);
        @(negedge CLK);
        check(tag, bus.wr_data, exp_word);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500; t++) begin
            @(negedge CLK);
            if (bus.wr_valid === 1'b0) break;
        end
        check("drain", 32'(bus.wr_valid), 32'h0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_sent   = 0;
        rdy_mode = 0;
        bus.in_valid = 1'b0; bus.in_class = '0; bus.in_cond = '0; bus.in_cmd = '0;
        bus.in_I = 1'b0; bus.in_S = 1'b0; bus.in_U = 1'b0; bus.in_L = 1'b0;
        bus.in_Rn = '0; bus.in_Rd = '0; bus.in_Rm = '0; bus.in_imm = '0; bus.in_last = 1'b0;
        bus.wr_ready = 1'b1;
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'h0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
        check("rst_word_count", 32'(bus.word_count), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err_illegal), 32'h0);
        check("rst_checksum", bus.checksum, 32'h0);
        Reset_n = 1'b1;
        @(posedge CLK);
        #1;

        // Known encodings
        send_expect("enc_add", 2'd0, 4'hE, 4'h4, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 24'd5, 32'hE2821005);
        check("add_word_count", 32'(bus.word_count), 32'h1);
        check("add_next_addr", 32'(bus.wr_addr), 32'h4);
        send_expect("enc_cmp", 2'd0, 4'hE, 4'hA, 0, 0, 0, 0, 4'd3, 4'd7, 4'd4, 24'd0, 32'hE1530004);
        send_expect("enc_ldr", 2'd1, 4'hE, 4'h0, 0, 0, 1, 1, 4'd6, 4'd5, 4'd0, 24'd8, 32'hE5965008);
        send_expect("enc_str", 2'd1, 4'hE, 4'h0, 0, 0, 0, 0, 4'd6, 4'd5, 4'd0, 24'd4, 32'hE5065004);
        send_expect("enc_b", 2'd2, 4'hE, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 32'hEAFFFFFE);

        do_reset();
        send(2'd0, 4'hE, 4'h4, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 24'd5, 1'b0);
        send(2'd2, 4'hE, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b0);
        wait_drain();
`ifdef ENC_CHECKSUM_EN
        check("checksum_pair", bus.checksum, 32'h2FFBDFF5);
`else
        check("checksum_off", bus.checksum, 32'h0);
`endif

        // Backpressure: fifth bundle must stall until the memory drains
        do_reset();
        rdy_mode = 1;
        bus.wr_ready = 1'b0;
        n_sent = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    send(2'd0, 4'hE, 4'h4, 1, 0, 0, 0, 4'd1, 4'd2, 4'd0, 24'(k + 1), 1'b0);
                    n_sent++;
                end
            end
            begin
                repeat (8) @(negedge CLK);
                check("bp_in_ready", 32'(bus.in_ready), 32'h0);
                check("bp_accepted", 32'(n_sent), 32'd4);
                rdy_mode = 0;
                bus.wr_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", 32'(bus.word_count), 32'd5);
        check("bp_addr", 32'(bus.wr_addr), 32'd20);

        // Illegal class, done set on last write and cleared by the next accept
        do_reset();
        send(2'd0, 4'hE, 4'h4, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 24'd5, 1'b0);
        send(2'd3, 4'hE, 4'h4, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 24'd5, 1'b0);
        send(2'd1, 4'hE, 4'h0, 0, 0, 1, 1, 4'd6, 4'd5, 4'd0, 24'd8, 1'b0);
        wait_drain();
        check("ill_count", 32'(bus.word_count), 32'd2);
        check("ill_addr", 32'(bus.wr_addr), 32'd8);
        check("ill_err", 32'(bus.err_illegal), 32'h1);
        send(2'd2, 4'hE, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 24'h000010, 1'b1);
        wait_drain();
        check("last_done", 32'(bus.done), 32'h1);
        send(2'd0, 4'hE, 4'hA, 0, 0, 0, 0, 4'd3, 4'd7, 4'd4, 24'd0, 1'b0);
        @(negedge CLK);
        check("done_cleared", 32'(bus.done), 32'h0);
        check("err_sticky", 32'(bus.err_illegal), 32'h1);
        wait_drain();

        // Random traffic with random memory backpressure
        rdy_mode = 2;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
            send(2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)), 4'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom),
                 1'($urandom_range(0, 7) == 0));
        end
        wait_drain();

        // Asynchronous reset with words still queued
        rdy_mode = 1;
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(2'd1, 4'h0, 4'h0, 0, 0, 1, 0, 4'(k), 4'(k + 1), 4'd0, 24'(k * 4), 1'b0);
        end
        #1 Reset_n = 1'b0;
        #1;
        check("arst_wr_valid", 32'(bus.wr_valid), 32'h0);
        check("arst_wr_addr", 32'(bus.wr_addr), 32'h0);
        check("arst_in_ready", 32'(bus.in_ready), 32'h1);
        check("arst_word_count", 32'(bus.word_count), 32'h0);
        check("arst_checksum", bus.checksum, 32'h0);
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        rdy_mode = 0;
        bus.wr_ready = 1'b1;
        @(posedge CLK);
        #1;
        send_expect("post_rst_enc", 2'd2, 4'hE, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE,
                    32'hEAFFFFFE);
        check("post_rst_addr", 32'(bus.wr_addr), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Field-level ARM instruction encoder and instruction-memory loader; inverse of the core's instruction decoder.
- Accepts decoded fields (class, cond, opcode, flags, registers, immediate) over a valid/ready handshake and packs them into 32-bit ARM words.
- Buffers encoded words in a small FIFO and streams them into instruction memory over a valid/ready write port with an auto-incrementing byte address.
- Used by the boot/test path to load programs before the core is released.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- ADDR_W, 10, width of the instruction-memory byte address
- BASE_ADDR, 0, first write address after reset (word-aligned)

Ports:
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_class  in  2  00 DP, 01 MEM, 10 Branch, 11 illegal
- in_cond  in  4  condition field
- in_cmd  in  4  DP opcode
- in_I  in  1  DP immediate operand select
- in_S  in  1  DP set-flags
- in_U  in  1  MEM add offset
- in_L  in  1  MEM load (1) / store (0)
- in_Rn, in_Rd, in_Rm  in  4 each  register fields
- in_imm  in  24  immediate (DP uses [7:0], MEM uses [11:0], Branch uses [23:0])
- in_last  in  1  marks final instruction of a program
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  ADDR_W  byte address
- wr_data  out  32  encoded instruction
- word_count  out  ADDR_W  words written since reset
- done  out  1  last-tagged word written
- err_illegal  out  1  sticky illegal-class flag
- checksum  out  32  see Optional Feature

Behaviour:
- Reset (async, Reset_n=0): FIFO empty, wr_addr=BASE_ADDR, word_count=0, done=0, err_illegal=0, checksum=0, wr_valid=0, in_ready=1.
- Accept: occurs when in_valid&&in_ready. in_ready = !full. No push when full, even with a simultaneous pop.
- Encoding (combinational, pushed on accept with in_last as a 33rd bit):
  - DP: {cond,2'b00,I,cmd,S',Rn,Rd',op2}.
    - op2 = I ? {4'h0,imm[7:0]} : {8'h00,Rm}.
    - For cmd 1000..1011: S' forced to 1 and Rd' forced to 0. Otherwise S'=S and Rd'=Rd.
  - MEM: {cond,2'b01,1'b0,1'b1,U,1'b0,1'b0,L,Rn,Rd,imm[11:0]}. Immediate offset, pre-index, word, no writeback.
  - Branch: {cond,3'b101,1'b0,imm[23:0]}.
  - Class 11: the bundle is accepted (handshake completes), nothing is pushed, and err_illegal is set. err_illegal clears only on reset.
- Latency: a word accepted at edge N appears at the FIFO head, with wr_valid=1, in the cycle after N.
- Write side:
  - wr_valid = !empty. wr_data is the FIFO head.
  - Transfer occurs when wr_valid&&wr_ready. On transfer: pop, wr_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1 (wraps).
  - wr_data and wr_addr stay stable while wr_valid=1 and wr_ready=0.
- FIFO:
  - Pointers are ADDR-independent, log2(DEPTH)+1 bits.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - Empty plus push: no pop that cycle.
- done:
  - Set on the edge of a transfer whose last bit is 1.
  - Cleared on the next accept.
  - If an accept and a last-word transfer coincide, set wins.
- Reset mid-stream: FIFO contents are discarded and the address returns to BASE_ADDR. There is no partial-write hazard, because a write exists only on a handshake.

Optional Feature:
- ENC_CHECKSUM_EN
  - Defined: checksum register; on each transfer, checksum <= {checksum[30:0],checksum[31]} ^ wr_data. Resets to 0.
  - Undefined: checksum tied to 32'h0 and no register is inferred.

Test Plan:
- ADD R1,R2,#5 (class 00, cond E, cmd 0100, I=1, S=0, Rn=2, Rd=1, imm=5), wr_ready=1 -> wr_data=0xE2821005 at wr_addr=0, one cycle after accept; word_count=1.
- CMP R3,R4 (cmd 1010, I=0, S=0, Rd=7, Rn=3, Rm=4) -> 0xE1530004 (S forced 1, Rd forced 0).
- LDR R5,[R6,#8] (U=1, L=1) -> 0xE5965008. STR R5,[R6,#-4] (U=0, L=0, imm=4) -> 0xE5065004. Branch cond E, imm 0xFFFFFE -> 0xEAFFFFFE.
- wr_ready=0, push 5 bundles continuously -> in_ready drops after the 4th accept; the 5th is held. Release wr_ready -> five writes at addresses 0,4,8,12,16 in input order.
- class 11 bundle between two valid ones -> err_illegal=1 (sticky); only 2 writes at addresses 0,4. Third bundle with in_last=1 -> done=1 after its write; the next accept clears done.
- Assert Reset_n=0 with 3 words queued -> wr_valid=0 and wr_addr=0 immediately. With ENC_CHECKSUM_EN, writing 0xE2821005 then 0xEAFFFFFE -> checksum=0xEAFFFFFE^0xC504200B=0x2FFBDFF5.
